// File: rtl/byte_data_memory.sv
// byte_data_memory: byte-addressable word memory with RISC-V load/store sizing and a configurable read latency
module byte_data_memory #(
    parameter int MEMORY_DEPTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] Read_Data,
    output logic                  misaligned
);
    localparam int AW = $clog2(MEMORY_DEPTH);
    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_next;
    logic [1:0] cnt;
    logic [31:0] mem [MEMORY_DEPTH];
    logic [AW-1:0] idx;
    logic [1:0] lane;
    logic accept, is_half, is_word, bad_f3, err, do_write, pend_err, unused_addr;
    logic [3:0] be;
    logic [31:0] wdata, word, shifted, load_val, result, pend_data;
    assign idx = Address[AW+1:2];
    assign lane = Address[1:0];
    assign unused_addr = ^Address[DATA_WIDTH-1:AW+2];
    assign req_ready = state == IDLE;
    assign resp_valid = state == RESP;
    always_comb begin
        accept = req_valid && state == IDLE;
        is_half = funct3[1:0] == 2'b01;
        is_word = funct3[1:0] == 2'b10;
        bad_f3 = funct3[1:0] == 2'b11 || (funct3[2] && (req_write || funct3[1]));
        err = bad_f3 || (is_half && lane[0]) || (is_word && lane != 2'b00);
        word = mem[idx];
        shifted = word >> {lane, 3'b000};
        load_val = is_word ? word
                 : is_half ? {{16{~funct3[2] & shifted[15]}}, shifted[15:0]}
                 : {{24{~funct3[2] & shifted[7]}}, shifted[7:0]};
        result = (req_write || err) ? 32'h0 : load_val;
        be = is_word ? 4'hF : is_half ? 4'b0011 << lane : 4'b0001 << lane;
        wdata = is_word ? Write_Data : is_half ? {2{Write_Data[15:0]}} : {4{Write_Data[7:0]}};
        do_write = accept && req_write && !err && !rst;
    end
    always_comb begin
        state_next = state;
        if (state == RESP)
            state_next = IDLE;
        else if (state == WAIT)
            state_next = cnt == 2'd0 ? RESP : WAIT;
        else if (accept)
            state_next = (req_write || READ_LATENCY == 1) ? RESP : WAIT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 2'd0;
            pend_data <= 32'h0;
            pend_err <= 1'b0;
            Read_Data <= '0;
            misaligned <= 1'b0;
        end else begin
            state <= state_next;
            cnt <= accept ? CNT_INIT : (state == WAIT && cnt != 2'd0) ? cnt - 2'd1 : cnt;
            if (accept) begin
                pend_data <= result;
                pend_err <= err;
            end
            // a response leaving IDLE directly uses this cycle's sample; from WAIT it uses the one held since accept
            if (state_next == RESP && state != RESP) begin
                Read_Data <= state == IDLE ? result : pend_data;
                misaligned <= state == IDLE ? err : pend_err;
            end
        end
    end
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (do_write && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: tb/tb_byte_data_memory.sv
// tb_byte_data_memory: directed checks on a latency-1 and a latency-3 instance
module tb_byte_data_memory;
    logic clk = 0, rst = 1, v1 = 0, v3 = 0, req_write = 0;
    logic [2:0] funct3 = 3'b010;
    logic [31:0] Address = 0, Write_Data = 0;
    logic rdy1, rdy3, rv1, rv3, mis1, mis3;
    logic [31:0] rd1, rd3;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    byte_data_memory #(.MEMORY_DEPTH(64), .DATA_WIDTH(32), .READ_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
        .funct3(funct3), .Address(Address), .Write_Data(Write_Data),
        .resp_valid(rv1), .Read_Data(rd1), .misaligned(mis1));
    byte_data_memory #(.MEMORY_DEPTH(64), .DATA_WIDTH(32), .READ_LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_write(req_write),
        .funct3(funct3), .Address(Address), .Write_Data(Write_Data),
        .resp_valid(rv3), .Read_Data(rd3), .misaligned(mis3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic access(input bit sel, input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_mis,
                          input string tag);
        int n = 0;
        bit got = 0;
        @(negedge clk);
        req_write = w; funct3 = f; Address = a; Write_Data = d;
        if (sel) v3 = 1; else v1 = 1;
        @(posedge clk);
        #1 v1 = 0; v3 = 0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (sel ? rv3 : rv1) got = 1;
        end
        check({tag, "_lat"}, n, (sel && !w) ? 3 : 1);
        check({tag, "_rd"}, sel ? rd3 : rd1, exp_rd);
        check({tag, "_mis"}, sel ? mis3 : mis1, exp_mis);
    endtask

    task automatic count_resp(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rv3) hits++;
        end
    endtask

    initial begin
        int hits;
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_ready", rdy1, 1);
        check("rst_resp", rv1, 0);
        check("rst_rd", rd1, 0);
        check("rst_mis", mis1, 0);
        // latency-1 instance
        access(0, 1, 3'b010, 32'h10, 32'h8000_00F1, 32'h0, 0, "sw10");
        access(0, 0, 3'b010, 32'h10, 0, 32'h8000_00F1, 0, "lw10");
        access(0, 1, 3'b000, 32'h13, 32'h1234_56AB, 32'h0, 0, "sb13");
        access(0, 0, 3'b000, 32'h13, 0, 32'hFFFF_FFAB, 0, "lb13");
        access(0, 0, 3'b100, 32'h13, 0, 32'h0000_00AB, 0, "lbu13");
        access(0, 0, 3'b010, 32'h10, 0, 32'hAB00_00F1, 0, "lw10b");
        access(0, 1, 3'b001, 32'h11, 32'hFFFF, 32'h0, 1, "sh11");
        access(0, 0, 3'b010, 32'h10, 0, 32'hAB00_00F1, 0, "lw10c");
        access(0, 0, 3'b010, 32'h12, 0, 32'h0, 1, "lw12");
        access(0, 0, 3'b001, 32'h12, 0, 32'hFFFF_AB00, 0, "lh12");
        access(0, 0, 3'b101, 32'h12, 0, 32'h0000_AB00, 0, "lhu12");
        access(0, 1, 3'b100, 32'h10, 32'h0, 32'h0, 1, "sbad");
        access(0, 0, 3'b110, 32'h10, 0, 32'h0, 1, "lbad");
        access(0, 0, 3'b010, 32'h10, 0, 32'hAB00_00F1, 0, "lw10d");
        access(0, 1, 3'b010, 32'h14, 32'h1122_3344, 32'h0, 0, "sw14");
        access(0, 1, 3'b001, 32'h16, 32'h5555_BEEF, 32'h0, 0, "sh16");
        access(0, 0, 3'b010, 32'h14, 0, 32'hBEEF_3344, 0, "lw14");
        access(0, 0, 3'b001, 32'h16, 0, 32'hFFFF_BEEF, 0, "lh16");
        access(0, 0, 3'b100, 32'h15, 0, 32'h0000_0033, 0, "lbu15");
        access(0, 0, 3'b000, 32'h14, 0, 32'h0000_0044, 0, "lb14");
        access(0, 1, 3'b010, 32'h100, 32'h1234_5678, 32'h0, 0, "sw100");
        access(0, 0, 3'b010, 32'h000, 0, 32'h1234_5678, 0, "lw000");
        repeat (3) @(negedge clk);
        check("hold_rd", rd1, 32'h1234_5678);
        check("hold_resp", rv1, 0);
        // latency-3 instance: held request during WAIT must not be re-accepted
        access(1, 1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, "sw20");
        @(negedge clk);
        req_write = 0; funct3 = 3'b010; Address = 32'h20; v3 = 1;
        @(negedge clk);
        check("c1_ready", rdy3, 0);
        check("c1_resp", rv3, 0);
        @(negedge clk);
        check("c2_ready", rdy3, 0);
        check("c2_resp", rv3, 0);
        @(negedge clk);
        check("c3_ready", rdy3, 0);
        check("c3_resp", rv3, 1);
        check("c3_rd", rd3, 32'hDEAD_BEEF);
        v3 = 0;
        @(negedge clk);
        check("c4_ready", rdy3, 1);
        count_resp(6, hits);
        check("no_extra_resp", hits, 0);
        // reset during WAIT aborts the response
        @(negedge clk);
        v3 = 1;
        @(posedge clk);
        #1 v3 = 0;
        @(negedge clk);
        check("wait_state", rdy3, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("post_rst_ready", rdy3, 1);
        check("post_rst_rd", rd3, 0);
        count_resp(6, hits);
        check("aborted_resp", hits, 0);
        // a store presented under reset is dropped
        @(negedge clk);
        rst = 1; v3 = 1; req_write = 1; funct3 = 3'b010; Address = 32'h20; Write_Data = 32'h0;
        @(negedge clk);
        rst = 0; v3 = 0;
        count_resp(4, hits);
        check("rst_store_resp", hits, 0);
        access(1, 0, 3'b010, 32'h20, 0, 32'hDEAD_BEEF, 0, "lw20");
        access(1, 0, 3'b001, 32'h21, 0, 32'h0, 1, "lh21");
        access(1, 0, 3'b000, 32'h21, 0, 32'hFFFF_FFBE, 0, "lb21");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 64, number of DATA_WIDTH-bit words (power of two, >=4).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 SHALL have parameter READ_LATENCY, default 1, cycles from read accept to resp_valid (legal 1..4).
REQ-004 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-009 SHALL have port funct3  input  3  RISC-V access size/sign code.
REQ-010 SHALL have port Address  input  DATA_WIDTH  byte address.
REQ-011 SHALL have port Write_Data  input  DATA_WIDTH  store data, right-aligned.
REQ-012 SHALL have port resp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port Read_Data  output  DATA_WIDTH  load result, extended to 32 bits.
REQ-014 SHALL have port misaligned  output  1  error flag, qualified by resp_valid.

Function
REQ-015 Storage SHALL be MEMORY_DEPTH words indexed by Address[log2(MEMORY_DEPTH)+1:2]; higher address bits are ignored, so addresses wrap.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1, req_ready=1 and rst=0.
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-018 IDLE->RESP on an accepted store, or on an accepted load when READ_LATENCY=1; IDLE->WAIT on an accepted load when READ_LATENCY>1.
REQ-019 WAIT SHALL load a down-counter with READ_LATENCY-2 at accept and go to RESP when the counter is 0; RESP->IDLE unconditionally.
REQ-020 resp_valid SHALL equal 1 exactly in RESP, one cycle per accepted request; responses have no backpressure.
REQ-021 Sizes: funct3 000/100 = byte, 001/101 = half, 010 = word; loads 000/001 sign-extend, 100/101 zero-extend; stores accept only 000/001/010.
REQ-022 Error SHALL be: half with Address[0]=1, word with Address[1:0]!=0, or an unsupported funct3.
REQ-023 A legal store SHALL update only the addressed byte lanes (lane = Address[1:0]), on the accept edge, using the low bytes of Write_Data.
REQ-024 A load SHALL sample memory on the accept edge; lane select and extension use Address[1:0] and funct3.
REQ-025 On an error access: memory SHALL be unchanged, Read_Data=0 and misaligned=1 at the response.
REQ-026 Stores SHALL respond with Read_Data=0 and misaligned=0 when legal.
REQ-027 Read_Data and misaligned SHALL update only when entering RESP and SHALL hold until the next response.
REQ-028 req_valid seen outside IDLE SHALL be ignored; the requester holds the request until req_ready=1.

Reset
REQ-029 rst=1 SHALL force IDLE, counter=0, req_ready=1 (from the next cycle), resp_valid=0, Read_Data=0 and misaligned=0.
REQ-030 rst SHALL take precedence over acceptance: no write and no response for a request presented during a rst=1 edge.
REQ-031 Reset in WAIT or RESP SHALL abort the pending response; no resp_valid follows.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 sw 0x8000_00F1 @0x10, then lw @0x10 with READ_LATENCY=1 -> resp_valid 1 cycle after accept, Read_Data=0x8000_00F1, misaligned=0.
REQ-034 sb 0xAB @0x13, then lb @0x13 -> 0xFFFF_FFAB; lbu @0x13 -> 0x0000_00AB; bytes 0x10..0x12 unchanged.
REQ-035 sh @0x11 -> misaligned=1, Read_Data=0, word at 0x10 unchanged; lw @0x12 -> misaligned=1.
REQ-036 READ_LATENCY=3, lw accepted at cycle 0 -> req_ready=0 in cycles 1-3, resp_valid exactly at cycle 3, req_valid held meanwhile not accepted.
REQ-037 MEMORY_DEPTH=64, sw 0x1234_5678 @0x100 -> lw @0x000 returns 0x1234_5678 (wrap).
REQ-038 rst=1 asserted in WAIT -> no resp_valid, req_ready=1 the cycle after rst deasserts, earlier stored data still readable.
